// File: rtl/shot_pool.sv
// -----------------------------------------------------------------------------
// shot_pool
//   Pool of NUM_SHOTS independent player shots. Each slot holds an active flag
//   and a top-left position. New shots launch on a fire button rising edge,
//   subject to a refresh-tick cooldown. Shots climb SHOT_VEL pixels per frame
//   and retire at the playfield top. Any covered pixel that also belongs to a
//   live alien retires the covering slot and reports a one-clock hit.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-high reset
//   pause         freezes slot, cooldown and hit state while high
//   refresh_tick  one-clock frame pulse; drives motion and cooldown
//   fire          shoot button (level)
//   orig_x/y      launch centre x / launch y (player top)
//   pixel_x/y     current VGA pixel
//   alien_on      current pixel belongs to a live alien
//   shot_pixel    current pixel covered by an active shot (combinational)
//   hit_pulse     one-clock collision pulse (registered)
//   hit_slot      index of the slot that hit (registered)
//   active_mask   per-slot active flags (registered)
//   active_count  number of active slots
// -----------------------------------------------------------------------------
module shot_pool #(
    parameter int NUM_SHOTS = 4,
    parameter int SHOT_W    = 2,
    parameter int SHOT_H    = 8,
    parameter int SHOT_VEL  = 4,
    parameter int COOLDOWN  = 15,
    parameter int Y_TOP     = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pause,
    input  logic                 refresh_tick,
    input  logic                 fire,
    input  logic [9:0]           orig_x,
    input  logic [9:0]           orig_y,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 alien_on,
    output logic                 shot_pixel,
    output logic                 hit_pulse,
    output logic [2:0]           hit_slot,
    output logic [NUM_SHOTS-1:0] active_mask,
    output logic [3:0]           active_count
);

    localparam int              CD_W       = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(COOLDOWN);
    localparam logic [9:0]      HALF_W     = 10'(SHOT_W / 2);
    localparam logic [9:0]      H10        = 10'(SHOT_H);
    localparam logic [9:0]      VEL10      = 10'(SHOT_VEL);
    localparam logic [9:0]      RETIRE_Y   = 10'(Y_TOP + SHOT_VEL);
    localparam logic [9:0]      FIRE_MIN_Y = 10'(Y_TOP + SHOT_H);
    localparam logic [10:0]     W11        = 11'(SHOT_W);
    localparam logic [10:0]     H11        = 11'(SHOT_H);

    logic [NUM_SHOTS-1:0] r_active;
    logic [9:0]           r_sx [NUM_SHOTS];
    logic [9:0]           r_sy [NUM_SHOTS];
    logic [CD_W-1:0]      r_cooldown;
    logic                 r_fire_q;
    logic                 r_armed;
    logic                 r_hit_pulse;
    logic [2:0]           r_hit_slot;

    logic [NUM_SHOTS-1:0] w_cover;
    logic [2:0]           w_cov_idx;
    logic [2:0]           w_free_idx;
    logic                 w_hit;
    logic                 w_fire_edge;
    logic                 w_accept;

    // Coverage uses 11-bit sums so a shot at the right edge cannot wrap to 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_cover = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            w_cover[i] = r_active[i]
                && ({1'b0, pixel_x} >= {1'b0, r_sx[i]})
                && ({1'b0, pixel_x} <  ({1'b0, r_sx[i]} + W11))
                && ({1'b0, pixel_y} >= {1'b0, r_sy[i]})
                && ({1'b0, pixel_y} <  ({1'b0, r_sy[i]} + H11));
        end
    end

    // Scanning downward leaves the lowest matching index in each result.
    always_comb begin
        w_cov_idx  = '0;
        w_free_idx = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (w_cover[i])   w_cov_idx  = 3'(i);
            if (!r_active[i]) w_free_idx = 3'(i);
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            active_count = active_count + 4'(r_active[i]);
        end
    end

    assign shot_pixel = |w_cover;
    assign w_hit      = alien_on & shot_pixel;

    // r_armed stays low for the first clock after reset so a button held
    // through reset release is first captured in r_fire_q and never seen
    // as an edge; a fresh press is required.
    assign w_fire_edge = fire & ~r_fire_q & r_armed;
    assign w_accept    = w_fire_edge
                      && (r_cooldown == '0)
                      && !(&r_active)
                      && (orig_y >= FIRE_MIN_Y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active    <= '0;
            // NOTE: the slot position arrays are small and cleared on reset so every register leaves reset at a known value.
            for (int i = 0; i < NUM_SHOTS; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
            end
            r_cooldown  <= '0;
            r_fire_q    <= 1'b0;
            r_armed     <= 1'b0;
            r_hit_pulse <= 1'b0;
            r_hit_slot  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_fire_q <= fire;
            r_armed  <= 1'b1;
            if (pause) begin
                r_hit_pulse <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_cooldown <= CD_LOAD;
                end else if (refresh_tick && (r_cooldown != '0)) begin
                    r_cooldown <= r_cooldown - 1'b1;
                end

                for (int i = 0; i < NUM_SHOTS; i++) begin
                    if (w_accept && (w_free_idx == 3'(i))) begin
                        // A slot loaded this clock does not move on this tick.
                        r_active[i] <= 1'b1;
                        r_sx[i]     <= orig_x - HALF_W;
                        r_sy[i]     <= orig_y - H10;
                    end else if (refresh_tick && r_active[i]) begin
                        if (r_sy[i] < RETIRE_Y) begin
                            r_active[i] <= 1'b0;
                        end else begin
                            r_sy[i] <= r_sy[i] - VEL10;
                        end
                    end
                    // Later assignment: a hit retires the slot even if it also moved.
                    if (w_hit && (w_cov_idx == 3'(i))) begin
                        r_active[i] <= 1'b0;
                    end
                end

                r_hit_pulse <= w_hit;
                if (w_hit) begin
                    r_hit_slot <= w_cov_idx;
                end
            end
        end
    end

    assign hit_pulse   = r_hit_pulse;
    assign hit_slot    = r_hit_slot;
    assign active_mask = r_active;

endmodule

// File: tb/tb_shot_pool.sv
// -----------------------------------------------------------------------------
// tb_shot_pool
//   Self-checking bench for shot_pool: directed scenarios followed by a long
//   randomized run, all compared against a behavioural pool model.
// -----------------------------------------------------------------------------
module tb_shot_pool;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int H   = 8;
    localparam int VEL = 4;
    localparam int CD  = 15;
    localparam int YT  = 36;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pause = 1'b0;
    logic         refresh_tick = 1'b0;
    logic         fire = 1'b0;
    logic [9:0]   orig_x = '0;
    logic [9:0]   orig_y = '0;
    logic [9:0]   pixel_x = '0;
    logic [9:0]   pixel_y = '0;
    logic         alien_on = 1'b0;
    logic         shot_pixel;
    logic         hit_pulse;
    logic [2:0]   hit_slot;
    logic [N-1:0] active_mask;
    logic [3:0]   active_count;

    shot_pool #(
        .NUM_SHOTS(N), .SHOT_W(W), .SHOT_H(H),
        .SHOT_VEL(VEL), .COOLDOWN(CD), .Y_TOP(YT)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause), .refresh_tick(refresh_tick),
        .fire(fire), .orig_x(orig_x), .orig_y(orig_y),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .alien_on(alien_on),
        .shot_pixel(shot_pixel), .hit_pulse(hit_pulse), .hit_slot(hit_slot),
        .active_mask(active_mask), .active_count(active_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit sp_seen;

    // Behavioural pool model
    bit m_active [N];
    int m_sx [N];
    int m_sy [N];
    int m_cd;
    bit m_fire_q;
    bit m_armed;
    bit m_hit_pulse;
    int m_hit_slot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cover_idx(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            if (m_active[i] && px >= m_sx[i] && px < m_sx[i] + W &&
                py >= m_sy[i] && py < m_sy[i] + H)
                return i;
        end
        return -1;
    endfunction

    function automatic int model_mask();
        int m = 0;
        for (int i = 0; i < N; i++) if (m_active[i]) m += (1 << i);
        return m;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_active[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 1'b0;
            m_sx[i] = 0;
            m_sy[i] = 0;
        end
        m_cd = 0;
        m_fire_q = 1'b0;
        m_armed = 1'b0;
        m_hit_pulse = 1'b0;
        m_hit_slot = 0;
    endtask

    task automatic model_advance(input bit f, input bit t, input bit p, input bit a,
                                 input int px, input int py);
        bit pressed;
        bit accept;
        int ci;
        int fi;
        pressed = f && !m_fire_q && m_armed;
        if (!p) begin
            ci = cover_idx(px, py);
            fi = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_active[i]) fi = i;
            accept = pressed && (m_cd == 0) && (fi >= 0) && (int'(orig_y) >= YT + H);
            if (t) begin
                for (int i = 0; i < N; i++) begin
                    if (m_active[i]) begin
                        if (m_sy[i] < YT + VEL) m_active[i] = 1'b0;
                        else m_sy[i] = m_sy[i] - VEL;
                    end
                end
            end
            if (accept) begin
                m_active[fi] = 1'b1;
                m_sx[fi] = (int'(orig_x) - W / 2) & 1023;
                m_sy[fi] = int'(orig_y) - H;
            end
            if (a && ci >= 0) begin
                m_active[ci] = 1'b0;
                m_hit_slot = ci;
                m_hit_pulse = 1'b1;
            end else begin
                m_hit_pulse = 1'b0;
            end
            if (accept) m_cd = CD;
            else if (t && m_cd > 0) m_cd = m_cd - 1;
        end else begin
            m_hit_pulse = 1'b0;
        end
        m_fire_q = f;
        m_armed = 1'b1;
    endtask

    // One clock: drive inputs, check the combinational pixel, clock, check registers.
    task automatic step(input bit f, input bit t, input bit p, input bit a,
                        input int px, input int py);
        int ci;
        fire = f;
        refresh_tick = t;
        pause = p;
        alien_on = a;
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        #1;
        ci = cover_idx(px, py);
        sp_seen = shot_pixel;
        check("shot_pixel", 32'(shot_pixel), 32'(ci >= 0));
        model_advance(f, t, p, a, px, py);
        @(posedge clk);
        #1;
        check("active_mask", 32'(active_mask), 32'(model_mask()));
        check("active_count", 32'(active_count), 32'(model_count()));
        check("hit_pulse", 32'(hit_pulse), 32'(m_hit_pulse));
        check("hit_slot", 32'(hit_slot), 32'(m_hit_slot));
    endtask

    task automatic apply_reset(input int px, input int py);
        reset = 1'b1;
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        alien_on = 1'b0;
        #1;
        model_reset();
        check("rst_mask", 32'(active_mask), 32'd0);
        check("rst_count", 32'(active_count), 32'd0);
        check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        check("rst_hit_slot", 32'(hit_slot), 32'd0);
        check("rst_shot_pixel", 32'(shot_pixel), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic ticks(input int n, input int px, input int py);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, px, py);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int px;
        int py;
        bit f;

        // 1: single launch and pixel coverage
        apply_reset(335, 412);
        orig_x = 10'd336;
        orig_y = 10'd420;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s1_mask", 32'(active_mask), 32'd1);
        check("s1_count", 32'(active_count), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 335, 412);
        check("s1_px_335_412", 32'(sp_seen), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 336, 419);
        check("s1_px_336_419", 32'(sp_seen), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 337, 412);
        check("s1_px_337_412", 32'(sp_seen), 32'd0);

        // 2: climb to the top and retire
        ticks(94, 335, 36);
        step(1'b0, 1'b0, 1'b0, 1'b0, 335, 36);
        check("s2_at_top", 32'(sp_seen), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 335, 35);
        check("s2_above_top", 32'(sp_seen), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check("s2_retired", 32'(active_mask), 32'd0);

        // 3: cooldown rejection, pool fill, full-pool rejection
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s3_first", 32'(active_mask), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s3_cd_reject", 32'(active_mask), 32'h1);
        for (int k = 1; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            ticks(16, 0, 0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            check("s3_fill", 32'(active_mask), 32'((1 << (k + 1)) - 1));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        ticks(16, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s3_full_reject", 32'(active_mask), 32'hF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 335, 156);
        check("s3_hit_slot0", 32'(active_mask), 32'hE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s3_cd_kept", 32'(active_mask), 32'hF);

        // 4: collision on slot 1
        apply_reset(0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        orig_x = 10'd400;
        orig_y = 10'd420;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        ticks(16, 0, 0);
        orig_x = 10'd201;
        orig_y = 10'd108;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s4_two", 32'(active_mask), 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 200, 103);
        check("s4_cover", 32'(sp_seen), 32'd1);
        check("s4_pulse", 32'(hit_pulse), 32'd1);
        check("s4_slot", 32'(hit_slot), 32'd1);
        check("s4_mask", 32'(active_mask), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 200, 103);
        check("s4_no_repeat", 32'(hit_pulse), 32'd0);

        // 5: pause freezes everything
        ticks(16, 0, 0);
        orig_x = 10'd300;
        orig_y = 10'd420;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s5_two", 32'(active_mask), 32'h3);
        for (int i = 0; i < 10; i++) begin
            step(1'((i + 1) % 2), 1'b1, 1'b1, 1'b1, 399, 284);
            check("s5_frozen_px", 32'(sp_seen), 32'd1);
            check("s5_no_pulse", 32'(hit_pulse), 32'd0);
            check("s5_mask", 32'(active_mask), 32'h3);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 299, 412);
        check("s5_slot1_held", 32'(sp_seen), 32'd1);

        // 6: reset mid-flight with fire held
        ticks(16, 0, 0);
        orig_x = 10'd500;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check("s6_three", 32'(active_mask), 32'h7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        #3;
        apply_reset(499, 412);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            check("s6_held_no_fire", 32'(active_mask), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 499, 412);
        check("s6_new_edge", 32'(active_mask), 32'h1);

        // Randomized run against the model
        apply_reset(0, 0);
        f = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) apply_reset(0, 0);
            if ($urandom_range(0, 2) == 0) f = ~f;
            orig_x = 10'($urandom_range(36, 600));
            orig_y = 10'($urandom_range(30, 470));
            s = int'($urandom_range(0, N - 1));
            if (m_active[s] && $urandom_range(0, 3) != 0) begin
                px = m_sx[s] + int'($urandom_range(0, W + 1)) - 1;
                py = m_sy[s] + int'($urandom_range(0, H + 1)) - 1;
            end else begin
                px = int'($urandom_range(0, 639));
                py = int'($urandom_range(0, 479));
            end
            step(f, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0), px, py);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
